hit_resolver: RTL and testbench
===============================

Name: hit_resolver

Overview:
Consumer end of the primitive-hit interface. For one ray, it collects a fixed number of per-primitive results from the sphere hit units. Each result is a valid flag plus HitData. The block keeps the nearest hit whose t lies in [t_min, t_max] and presents a single registered closest-hit result downstream through a valid/ready handshake. It sits between the primitive test array and the shading stage.

Parameters:
NUM_PRIMS, 8, number of primitive results consumed per ray (≥1).
CNT_W, $clog2(NUM_PRIMS+1), width of the result counter.

Ports:
clk  input  1  clock, all state on rising edge
resetn  input  1  asynchronous reset, active-high (asserted = 1, despite name)
start  input  1  begin a new ray; sampled only in IDLE
t_min  input  Fixed  lower bound on t, signed; latched on accepted start
t_max  input  Fixed  upper bound on t, signed; latched on accepted start
in_valid  input  1  a primitive result is present
in_ready  output  1  resolver accepts a result this cycle
in_hit  input  1  primitive reports an intersection (the SphereHit valid)
in_data  input  HitData  hit record; in_data.T is the signed Fixed ray parameter
out_valid  output  1  closest-hit result available
out_ready  input  1  downstream consumes the result
out_hit  output  1  at least one in-range hit was found
out_data  output  HitData  nearest in-range hit record; all-zero when out_hit=0
busy  output  1  high in COLLECT or OUTPUT

Behaviour:
- Reset (async, resetn=1): state=IDLE; in_ready=0, out_valid=0, out_hit=0, out_data=0, busy=0. Counter, best-valid flag and latched bounds are cleared. Reset mid-ray discards all partial results, and no output is produced for that ray.
- Input transfer: occurs when in_valid && in_ready. Output transfer: occurs when out_valid && out_ready.
- States: IDLE, COLLECT, OUTPUT.
- IDLE:
  - in_ready=0, out_valid=0.
  - start=1 → latch t_min/t_max, clear count and best_valid, go to COLLECT next cycle.
- COLLECT:
  - in_ready=1 (combinational from state only, never from in_valid).
  - On each input transfer, count increments.
  - A result is a candidate when in_hit=1 && in_data.T ≥ t_min && in_data.T ≤ t_max (signed compares, bounds inclusive).
  - A candidate replaces best when best_valid=0 or in_data.T < best.T (strictly less). On ties, the earlier-arrived result is kept.
  - Results with in_hit=0 or out-of-range t are counted and otherwise ignored.
  - When the transfer brings count to NUM_PRIMS, go to OUTPUT. Registered outputs update on that same edge.
- OUTPUT:
  - out_valid=1; out_hit=best_valid; out_data=best (or zero if !best_valid); in_ready=0.
  - Outputs are held stable until out_ready=1. On the transfer, go to IDLE next cycle with out_valid=0.
- Latency: out_valid rises the cycle after the NUM_PRIMS-th input transfer. There is no combinational path from any input to any output.
- start in COLLECT or OUTPUT is ignored. It is not queued.
- in_valid in IDLE/OUTPUT is not accepted (in_ready=0).
- t_min > t_max: no result can qualify, so out_hit=0.
- Gaps in in_valid during COLLECT are legal. The block waits indefinitely.
- out_ready held high in IDLE has no effect.
- Minimum per-ray occupancy: 1 (start) + NUM_PRIMS + 1 cycles.

Test Plan:
1. Reset with resetn=1 for 3 cycles, mid-COLLECT after 3 of 8 results → all outputs 0, state IDLE; a following full 8-result ray produces one correct output unaffected by the pre-reset results.
2. NUM_PRIMS=8, t_min=0, t_max=100.0; in_hit=1 with T={50,20,70,20,90,30,60,40}, data tagged by index → out_hit=1, out_data is index 1 (T=20, tie kept earlier); out_valid exactly 1 cycle after the 8th transfer.
3. Hits with T={-5,150,100,0} plus 4 misses, bounds [0,100] → out_hit=1, T=0 (inclusive lower bound); T=100 loses; -5 and 150 are rejected.
4. All in_hit=0 → out_hit=1'b0, out_data=0, out_valid=1; with out_ready held low 10 cycles, outputs stay stable, then return to IDLE the cycle after out_ready=1.
5. in_valid toggling randomly with gaps, start pulsed during COLLECT and OUTPUT → start ignored, exactly 8 transfers counted, single output per ray.
6. Back-to-back rays: start asserted the cycle after the output transfer, with t_min=10, t_max=5 → second ray reports out_hit=0 regardless of inputs.

Source files
------------

// File: rtl/hit_resolver.sv
// hit_resolver
//   Consumer end of the primitive-hit interface. For one ray it accepts
//   NUM_PRIMS per-primitive results. It keeps the nearest hit whose t lies
//   inside the latched [t_min, t_max] window, bounds included. It then
//   presents one registered closest-hit record downstream through a
//   valid/ready handshake.
//
//   HitData layout: {tag[TAG_W-1:0], t[DATA_W-1:0]}. The signed fixed-point
//   ray parameter T occupies the low DATA_W bits. The tag field is an opaque
//   payload that travels with the winning record.
//
// Ports
//   clk        clock, all state on rising edge
//   resetn     asynchronous reset, active-high (asserted = 1)
//   start      begin a new ray (sampled only while idle)
//   t_min      signed lower bound on t, latched on accepted start
//   t_max      signed upper bound on t, latched on accepted start
//   in_valid   a primitive result is present
//   in_ready   resolver accepts a result this cycle
//   in_hit     primitive reports an intersection
//   in_data    hit record
//   out_valid  closest-hit result available
//   out_ready  downstream consumes the result
//   out_hit    at least one in-range hit was found
//   out_data   nearest in-range hit record, zero when out_hit = 0
//   busy       ray in flight (collecting or presenting)
module hit_resolver #(
    parameter int NUM_PRIMS = 8,
    parameter int CNT_W     = $clog2(NUM_PRIMS + 1),
    parameter int DATA_W    = 32,
    parameter int TAG_W     = 16,
    parameter int HIT_W     = DATA_W + TAG_W
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     start,
    input  logic signed [DATA_W-1:0] t_min,
    input  logic signed [DATA_W-1:0] t_max,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_hit,
    input  logic [HIT_W-1:0]         in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_hit,
    output logic [HIT_W-1:0]         out_data,
    output logic                     busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        OUTPUT  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0]         cnt_q;
    logic                     best_valid_q;
    logic [HIT_W-1:0]         best_q;
    logic signed [DATA_W-1:0] t_min_q;
    logic signed [DATA_W-1:0] t_max_q;
    logic                     out_hit_q;
    logic [HIT_W-1:0]         out_data_q;

    logic signed [DATA_W-1:0] in_t;
    logic signed [DATA_W-1:0] best_t;
    logic                     xfer_in;
    logic                     last_in;
    logic                     cand;
    logic                     take;
    logic                     best_valid_nxt;
    logic [HIT_W-1:0]         best_nxt;

    // Inclusive signed window test on the ray parameter.
    function automatic logic t_in_window(
        input logic signed [DATA_W-1:0] t,
        input logic signed [DATA_W-1:0] lo,
        input logic signed [DATA_W-1:0] hi
    );
        return (t >= lo) && (t <= hi);
    endfunction

    assign in_t   = in_data[DATA_W-1:0];
    assign best_t = best_q[DATA_W-1:0];

    // Handshake signals come from the state register only, so nothing on
    // the input side can reach an output combinationally.
    assign in_ready  = (state_q == COLLECT);
    assign out_valid = (state_q == OUTPUT);
    assign busy      = (state_q != IDLE);
    assign out_hit   = out_hit_q;
    assign out_data  = out_data_q;

    assign xfer_in = in_valid && (state_q == COLLECT);
    assign last_in = xfer_in && (cnt_q == CNT_W'(NUM_PRIMS - 1));

    // Strict less-than keeps the earlier arrival on equal t.
    assign cand           = in_hit && t_in_window(in_t, t_min_q, t_max_q);
    assign take           = cand && (!best_valid_q || (in_t < best_t));
    assign best_valid_nxt = best_valid_q || cand;
    assign best_nxt       = take ? in_data : best_q;

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)     state_d = COLLECT;
            COLLECT: if (last_in)   state_d = OUTPUT;
            OUTPUT:  if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Collection stage: running nearest-hit tracking and result register.
    // The last transfer loads the result from the merged best so that the
    // final result can still win.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            cnt_q        <= '0;
            best_valid_q <= 1'b0;
            best_q       <= '0;
            t_min_q      <= '0;
            t_max_q      <= '0;
            out_hit_q    <= 1'b0;
            out_data_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        t_min_q      <= t_min;
                        t_max_q      <= t_max;
                        cnt_q        <= '0;
                        best_valid_q <= 1'b0;
                        best_q       <= '0;
                    end
                end
                COLLECT: begin
                    if (xfer_in) begin
                        cnt_q        <= cnt_q + CNT_W'(1);
                        best_valid_q <= best_valid_nxt;
                        best_q       <= best_nxt;
                        if (last_in) begin
                            out_hit_q  <= best_valid_nxt;
                            out_data_q <= best_valid_nxt ? best_nxt : '0;
                        end
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        out_hit_q  <= 1'b0;
                        out_data_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hit_resolver.sv
// tb_hit_resolver
//   Directed bench for hit_resolver. A reference model kept in one negedge
//   process rebuilds each ray from the observed input transfers. It picks
//   the expected winner by scanning the whole ray, and compares every
//   handshake and data output each cycle. A table of hand-computed results
//   pins the model, one entry per completed ray.
module tb_hit_resolver;

    localparam int NUM_PRIMS = 8;
    localparam int DATA_W    = 32;
    localparam int TAG_W     = 16;
    localparam int HIT_W     = DATA_W + TAG_W;
    localparam int NUM_RAYS  = 7;

    logic                     clk;
    logic                     resetn;
    logic                     start;
    logic signed [DATA_W-1:0] t_min;
    logic signed [DATA_W-1:0] t_max;
    logic                     in_valid;
    logic                     in_ready;
    logic                     in_hit;
    logic [HIT_W-1:0]         in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic                     out_hit;
    logic [HIT_W-1:0]         out_data;
    logic                     busy;

    hit_resolver #(
        .NUM_PRIMS(NUM_PRIMS),
        .DATA_W   (DATA_W),
        .TAG_W    (TAG_W)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .start    (start),
        .t_min    (t_min),
        .t_max    (t_max),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_hit   (in_hit),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_hit  (out_hit),
        .out_data (out_data),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests    = 0;
    int errs     = 0;
    int n_out    = 0;
    int timeouts = 0;
    bit done     = 1'b0;

    logic             lit_hit  [NUM_RAYS];
    logic [HIT_W-1:0] lit_data [NUM_RAYS];

    function automatic logic [DATA_W-1:0] fx(input int v);
        return DATA_W'(v * 65536);
    endfunction

    function automatic logic [HIT_W-1:0] hd(input int tag, input int tv);
        logic [TAG_W-1:0] tg;
        tg = tag[TAG_W-1:0];
        return {tg, fx(tv)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model and compare process
    // ------------------------------------------------------------------
    int                       m_phase = 0;   // 0 idle, 1 collecting, 2 presenting
    logic signed [DATA_W-1:0] m_lo, m_hi;
    logic [HIT_W-1:0]         m_data [$];
    bit                       m_hit  [$];
    logic                     exp_hit;
    logic [HIT_W-1:0]         exp_data;

    always @(negedge clk) begin
        if (resetn) begin
            m_phase = 0;
            m_data.delete();
            m_hit.delete();
        end

        chk("in_ready", in_ready, m_phase == 1);
        chk("out_valid", out_valid, m_phase == 2);
        chk("busy", busy, m_phase != 0);
        if (m_phase == 2) begin
            chk("out_hit", out_hit, exp_hit);
            chk("out_data", out_data, exp_data);
        end else if (resetn) begin
            chk("rst_out_hit", out_hit, 0);
            chk("rst_out_data", out_data, 0);
        end

        if (!resetn) begin
            case (m_phase)
                0: if (start) begin
                    m_lo = t_min;
                    m_hi = t_max;
                    m_data.delete();
                    m_hit.delete();
                    m_phase = 1;
                end
                1: if (in_valid) begin
                    m_data.push_back(in_data);
                    m_hit.push_back(in_hit);
                    if (m_data.size() == NUM_PRIMS) begin
                        bit found;
                        logic signed [DATA_W-1:0] bt;
                        logic signed [DATA_W-1:0] t;
                        found = 1'b0;
                        bt = '0;
                        exp_data = '0;
                        foreach (m_data[i]) begin
                            t = m_data[i][DATA_W-1:0];
                            if (m_hit[i] && t >= m_lo && t <= m_hi && (!found || t < bt)) begin
                                found = 1'b1;
                                bt = t;
                                exp_data = m_data[i];
                            end
                        end
                        exp_hit = found;
                        m_phase = 2;
                    end
                end
                2: if (out_ready) begin
                    if (n_out < NUM_RAYS) begin
                        chk("lit_hit", out_hit, lit_hit[n_out]);
                        chk("lit_data", out_data, lit_data[n_out]);
                    end
                    n_out++;
                    m_phase = 0;
                end
                default: m_phase = 0;
            endcase
        end

        if (done) begin
            chk("num_outputs", n_out, NUM_RAYS);
            chk("timeouts", timeouts, 0);
            $display("[TB] %0d tests run, %0d failed", tests, errs);
            $finish;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int lo, input int hi);
        start = 1'b1;
        t_min = fx(lo);
        t_max = fx(hi);
        tick();
        start = 1'b0;
    endtask

    task automatic send(input bit hit, input int tv, input int tag, input int gap, input bit pstart);
        int g;
        g = (pstart && gap == 0) ? 1 : gap;
        for (int k = 0; k < g; k++) begin
            in_valid = 1'b0;
            start    = pstart && (k == 0);
            tick();
        end
        start    = 1'b0;
        in_valid = 1'b1;
        in_hit   = hit;
        in_data  = hd(tag, tv);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_output(input int hold, input bit pstart, input bit chain,
                               input int lo, input int hi);
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        if (!out_valid) timeouts++;
        if (pstart) begin
            start = 1'b1;
            tick();
            tick();
            start = 1'b0;
        end
        repeat (hold) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        if (chain) begin
            start = 1'b1;
            t_min = fx(lo);
            t_max = fx(hi);
            tick();
            start = 1'b0;
        end
    endtask

    initial begin
        int t2 [8];
        int t6a [8];
        int t6b [8];
        t2  = '{50, 20, 70, 20, 90, 30, 60, 40};
        t6a = '{80, 60, 12, 99, 100, 101, -1, 33};
        t6b = '{7, 8, 6, 10, 5, 9, 7, 6};

        lit_hit[0] = 1'b1; lit_data[0] = hd(11, 30);
        lit_hit[1] = 1'b1; lit_data[1] = hd(1, 20);
        lit_hit[2] = 1'b1; lit_data[2] = hd(3, 0);
        lit_hit[3] = 1'b0; lit_data[3] = '0;
        lit_hit[4] = 1'b1; lit_data[4] = hd(7, 2);
        lit_hit[5] = 1'b1; lit_data[5] = hd(2, 12);
        lit_hit[6] = 1'b0; lit_data[6] = '0;

        resetn    = 1'b1;
        start     = 1'b0;
        t_min     = '0;
        t_max     = '0;
        in_valid  = 1'b0;
        in_hit    = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) tick();
        resetn = 1'b0;
        tick();

        // Reset mid-ray: three strong candidates, then a 3-cycle reset.
        do_start(0, 100);
        for (int i = 0; i < 3; i++) send(1'b1, i + 1, 100 + i, 0, 1'b0);
        resetn = 1'b1;
        repeat (3) tick();
        resetn = 1'b0;
        tick();
        do_start(0, 100);
        send(1'b1, 40, 10, 0, 1'b0);
        send(1'b1, 30, 11, 0, 1'b0);
        send(1'b1, 35, 12, 0, 1'b0);
        send(1'b1, 60, 13, 0, 1'b0);
        send(1'b1, 45, 14, 0, 1'b0);
        send(1'b1, 70, 15, 0, 1'b0);
        send(1'b1, 80, 16, 0, 1'b0);
        send(1'b1, 90, 17, 0, 1'b0);
        wait_output(0, 1'b0, 1'b0, 0, 0);

        // Nearest with a tie: the earlier T=20 must win.
        do_start(0, 100);
        for (int i = 0; i < 8; i++) send(1'b1, t2[i], i, 0, 1'b0);
        wait_output(0, 1'b0, 1'b0, 0, 0);

        // Window bounds: -5 and 150 rejected, 0 beats 100, misses ignored.
        do_start(0, 100);
        send(1'b1, -5, 0, 0, 1'b0);
        send(1'b1, 150, 1, 0, 1'b0);
        send(1'b1, 100, 2, 0, 1'b0);
        send(1'b1, 0, 3, 0, 1'b0);
        for (int i = 4; i < 8; i++) send(1'b0, 1, i, 0, 1'b0);
        wait_output(0, 1'b0, 1'b0, 0, 0);

        // No hits; the result is held while out_ready stays low.
        do_start(0, 100);
        for (int i = 0; i < 8; i++) send(1'b0, 10 * i, i, 0, 1'b0);
        wait_output(10, 1'b0, 1'b0, 0, 0);

        // Gapped input with start pulses while collecting and presenting.
        do_start(0, 100);
        for (int i = 0; i < 8; i++)
            send(1'b1, 9 - i, i, $urandom_range(0, 3), (i == 2) || (i == 5));
        wait_output(2, 1'b1, 1'b0, 0, 0);
        out_ready = 1'b1;
        repeat (3) tick();
        out_ready = 1'b0;

        // Back-to-back rays; the second has an empty window (t_min > t_max).
        do_start(0, 100);
        for (int i = 0; i < 8; i++) send(1'b1, t6a[i], i, 0, 1'b0);
        wait_output(0, 1'b0, 1'b1, 10, 5);
        for (int i = 0; i < 8; i++) send(1'b1, t6b[i], i, 0, 1'b0);
        wait_output(1, 1'b0, 1'b0, 0, 0);

        repeat (2) tick();
        done = 1'b1;
        repeat (5) tick();
        $display("FAIL end_of_test: summary not reached, n_out=%0d", n_out);
        $fatal(1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, n_out=%0d", n_out);
        $fatal(1);
    end

endmodule
